frame_stream_filter: RTL and testbench
======================================

Name: frame_stream_filter

Overview:
- Parametrised successor to the single-image pixel streamer: streams one of NUM_IMAGES BRAM-resident images as an Avalon-ST video frame, applying a selectable colour filter.
- Generalises resolution, colour depth and image count.
- Pipeline is fully elastic under backpressure, and all controls are frame-atomic, latched at frame start.
- Sits between image ROMs and the VGA Avalon-ST sink.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- CH_BITS, 1, bits per colour channel in ROM; legal values 1, 2, 4, 8; pixel word = 3*CH_BITS as {R,G,B}
- NUM_IMAGES, 3, number of image ROMs; init files image0.mif .. image(N-1).mif
- PITCH_LO, 3000, pitch threshold, red/green split
- PITCH_HI, 5000, pitch threshold, green/blue split

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- face_select  in  $clog2(NUM_IMAGES)  image index; out-of-range value selects image 0
- filter_mode  in  3  0 pass, 1 grey, 2 rotate-left, 3 rotate-right, 4 invert, 5 pitch-key, 6-7 pass
- mic_en  in  1  microphone enabled
- pitch  in  16  unsigned pitch estimate
- data  out  30  {R8,2'b00,G8,2'b00,B8,2'b00}
- startofpacket  out  1  asserted on pixel 0 beat
- endofpacket  out  1  asserted on last-pixel beat
- valid  out  1  Avalon-ST valid
- ready  in  1  Avalon-ST ready
- frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset values: valid=0, data=0, startofpacket=0, endofpacket=0, frame_count=0, pixel address=0, stage-1 valid=0.
- Reset mid-frame: pipeline flushed; next frame restarts at pixel 0; no partial-frame eop is emitted.
- Pipeline stages:
  - A: address counter
  - S1: registered ROM read, plus sop/eop flags
  - S2: filter, then output register
- Global enable: en = ~valid | ready. When en=0, every stage, the ROM read enable and the address all hold.
- Backpressure: while valid & ~ready, data, startofpacket and endofpacket remain stable.
- Latency: the first clock edge with reset low reads pixel 0; valid asserts after the second edge with reset low. With ready held high, there is one pixel per cycle and no bubbles, including across frame boundaries.
- Address: increments on en; wraps from H_RES*V_RES-1 to 0.
- Control latch: face_select, filter_mode, mic_en and pitch are sampled into shadow registers when address 0 is issued with en=1 (including the first cycle after reset). A mid-frame input change takes effect from the next frame only.
- Sideband flags: sop/eop travel with their pixel through S1/S2.
- frame_count: increments on the handshake (valid & ready) of the eop beat.
- Channel expansion: each CH_BITS value is replicated MSB-first and truncated to 8 bits (CH_BITS=1, value 1 -> 8'hFF; CH_BITS=2, 2'b10 -> 8'hAA).
- Filter modes, applied on CH_BITS values before expansion:
  - pass: R,G,B unchanged
  - grey: Y = floor((R+G+B)/3), exact integer division with no approximation; output Y,Y,Y
  - rotate-left: out = {G,B,R}
  - rotate-right: out = {B,R,G}
  - invert: each channel = max - value
  - pitch-key: if ~mic_en, grey. Else if pitch <= PITCH_LO, {R,Y,Y}. Else if pitch <= PITCH_HI, {Y,G,Y}. Else {Y,Y,B}.
- Sum width: the R+G+B sum is CH_BITS+2 bits; no overflow.

Decomposition:
- Package pixel_stream_pkg:
  - filter_mode_t enum
  - AVST_DATA_W=30
  - function expand_ch (replication)
  - function grey3 (exact divide-by-3)
- Sub-module pixel_colour_filter: combinational; inputs are the pixel word plus latched mode/mic_en/pitch; output is the filtered {R,G,B} at CH_BITS each. The top-level module registers the result.

Test Plan:
- H_RES=4, V_RES=2, CH_BITS=1, ready=1, mode 0, ROM 0..7 = pixel index -> valid rises 2 edges after reset release; data matches expansion of 0..7; sop on beat 0, eop on beat 7; frame_count=1 after eop; next frame starts back-to-back.
- Backpressure: ready toggled with the pattern 1,0,0,1 -> no beat dropped or duplicated; data/sop/eop stable during each ready=0 cycle.
- CH_BITS=2, mode 1, pixel {3,2,0} -> Y=1; data={8'h55,2'b00,8'h55,2'b00,8'h55,2'b00}.
- Mode 5, mic_en=1, CH_BITS=1, pixel {1,0,1}, Y=0: pitch=3000 -> R=FF,G=00,B=00; pitch=5001 -> B=FF, R/G=00.
- filter_mode and face_select changed at pixel 3 -> rest of frame unchanged; new settings apply from the next sop.
- Reset asserted at pixel 5 for 1 cycle -> valid=0 during reset; restart at pixel 0 with sop; frame_count reset to 0.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// pixel_stream_pkg : shared types and helpers for the frame streamer
// Rev 1.0
// ============================================================================
package pixel_stream_pkg;

    localparam int AVST_DATA_W = 30;

    typedef enum logic [2:0] {
        FM_PASS      = 3'd0,
        FM_GREY      = 3'd1,
        FM_ROTL      = 3'd2,
        FM_ROTR      = 3'd3,
        FM_INVERT    = 3'd4,
        FM_PITCH_KEY = 3'd5
    } filter_mode_t;

    // Replicate the low ch_bits of value MSB-first across 8 bits.
    function automatic logic [7:0] expand_ch(input logic [7:0] value, input int ch_bits);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[3'(7 - i)] = value[3'(ch_bits - 1 - (i % ch_bits))];
        end
        return res;
    endfunction

    function automatic logic [7:0] grey3(input logic [9:0] sum);
        return 8'(sum / 10'd3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_colour_filter.sv
`default_nettype none
// ============================================================================
// pixel_colour_filter : combinational colour filter on CH_BITS-wide channels
// Rev 1.0
// ============================================================================
module pixel_colour_filter
    import pixel_stream_pkg::*;
#(
    parameter int CH_BITS  = 1,
    parameter int PITCH_LO = 3000,
    parameter int PITCH_HI = 5000
) (
    input  logic [3*CH_BITS-1:0] pix_in,
    input  logic [2:0]           mode,
    input  logic                 mic_en,
    input  logic [15:0]          pitch,
    output logic [3*CH_BITS-1:0] pix_out
);

    localparam logic [15:0] PITCH_LO16 = 16'(PITCH_LO);
    localparam logic [15:0] PITCH_HI16 = 16'(PITCH_HI);

    logic [CH_BITS-1:0] r, g, b, y;
    logic [CH_BITS+1:0] sum;

    assign r   = pix_in[3*CH_BITS-1 -: CH_BITS];
    assign g   = pix_in[2*CH_BITS-1 -: CH_BITS];
    assign b   = pix_in[CH_BITS-1:0];
    assign sum = (CH_BITS+2)'(r) + (CH_BITS+2)'(g) + (CH_BITS+2)'(b);
    assign y   = CH_BITS'(grey3(10'(sum)));

    always_comb begin
        pix_out = {r, g, b};
        case (mode)
            FM_GREY:   pix_out = {y, y, y};
            FM_ROTL:   pix_out = {g, b, r};
            FM_ROTR:   pix_out = {b, r, g};
            FM_INVERT: pix_out = ~{r, g, b};
            FM_PITCH_KEY: begin
                if (!mic_en)                  pix_out = {y, y, y};
                else if (pitch <= PITCH_LO16) pix_out = {r, y, y};
                else if (pitch <= PITCH_HI16) pix_out = {y, g, y};
                else                          pix_out = {y, y, b};
            end
            default:   pix_out = {r, g, b};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/frame_stream_filter.sv
`default_nettype none
// ============================================================================
// frame_stream_filter : streams a ROM image as an Avalon-ST frame via a filter
// Rev 1.0
// ============================================================================
module frame_stream_filter
    import pixel_stream_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int CH_BITS    = 1,
    parameter int NUM_IMAGES = 3,
    parameter int PITCH_LO   = 3000,
    parameter int PITCH_HI   = 5000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(NUM_IMAGES)-1:0] face_select,
    input  logic [2:0]                    filter_mode,
    input  logic                          mic_en,
    input  logic [15:0]                   pitch,
    output logic [AVST_DATA_W-1:0]        data,
    output logic                          startofpacket,
    output logic                          endofpacket,
    output logic                          valid,
    input  logic                          ready,
    output logic [15:0]                   frame_count
);

    localparam int NPIX   = H_RES * V_RES;
    localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PIX_W  = 3 * CH_BITS;
    localparam int FACE_W = $clog2(NUM_IMAGES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    logic                                en;
    logic [ADDR_W-1:0]                   addr;
    logic [FACE_W-1:0]                   face_sh;
    logic [2:0]                          mode_sh;
    logic                                mic_sh;
    logic [15:0]                         pitch_sh;
    logic                                s1_valid, s1_sop, s1_eop;
    logic [NUM_IMAGES-1:0][PIX_W-1:0]    rom_q;
    logic [PIX_W-1:0]                    s1_pix, filt_pix;

    assign en = ~valid | ready;

    for (genvar k = 0; k < NUM_IMAGES; k++) begin : g_img
        (* ram_init_file = {"image", 8'd48 + 8'(k), ".mif"} *)
        logic [PIX_W-1:0] mem [NPIX] = '{default: '0};
        logic [PIX_W-1:0] q;

        always_ff @(posedge clk) begin
            if (en) q <= mem[addr];
        end

        assign rom_q[k] = q;
    end

    // Every ROM is read in parallel; the frame-latched face picks the word.
    assign s1_pix = rom_q[face_sh];

    pixel_colour_filter #(
        .CH_BITS  (CH_BITS),
        .PITCH_LO (PITCH_LO),
        .PITCH_HI (PITCH_HI)
    ) u_filter (
        .pix_in  (s1_pix),
        .mode    (mode_sh),
        .mic_en  (mic_sh),
        .pitch   (pitch_sh),
        .pix_out (filt_pix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            addr          <= '0;
            face_sh       <= '0;
            mode_sh       <= '0;
            mic_sh        <= 1'b0;
            pitch_sh      <= '0;
            s1_valid      <= 1'b0;
            s1_sop        <= 1'b0;
            s1_eop        <= 1'b0;
            valid         <= 1'b0;
            startofpacket <= 1'b0;
            endofpacket   <= 1'b0;
            data          <= '0;
        end else if (en) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            // Controls are frame-atomic: captured as pixel 0 is issued.
            if (addr == '0) begin
                face_sh  <= (32'(face_select) < NUM_IMAGES) ? face_select : '0;
                mode_sh  <= filter_mode;
                mic_sh   <= mic_en;
                pitch_sh <= pitch;
            end
            s1_valid      <= 1'b1;
            s1_sop        <= (addr == '0);
            s1_eop        <= (addr == LAST_ADDR);
            valid         <= s1_valid;
            startofpacket <= s1_sop;
            endofpacket   <= s1_eop;
            data          <= {expand_ch(8'(filt_pix[3*CH_BITS-1 -: CH_BITS]), CH_BITS), 2'b00,
                              expand_ch(8'(filt_pix[2*CH_BITS-1 -: CH_BITS]), CH_BITS), 2'b00,
                              expand_ch(8'(filt_pix[CH_BITS-1:0]), CH_BITS), 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (valid && ready && endofpacket) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_filter.sv
`default_nettype none
// ============================================================================
// tb_frame_stream_filter : directed bench for frame_stream_filter
// Rev 1.0
// ============================================================================
module tb_frame_stream_filter;

    localparam int K_PASS   = 0;
    localparam int K_INV1   = 1;
    localparam int K_ROTL   = 2;
    localparam int K_PK_LO  = 3;
    localparam int K_PK_HI  = 4;
    localparam int K_PK_MID = 5;
    localparam int K_ROTR   = 6;
    localparam int K_GREY   = 7;

    logic        clk, reset;
    logic [1:0]  face1;
    logic [2:0]  mode1;
    logic        mic1;
    logic [15:0] pitch1;
    logic [29:0] data1;
    logic        sop1, eop1, valid1, ready1;
    logic [15:0] fc1;

    logic [0:0]  face2;
    logic [2:0]  mode2;
    logic        mic2;
    logic [15:0] pitch2;
    logic [29:0] data2;
    logic        sop2, eop2, valid2, ready2;
    logic [15:0] fc2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic bp_on = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int   bp_idx = 0;

    frame_stream_filter #(
        .H_RES(4), .V_RES(2), .CH_BITS(1), .NUM_IMAGES(3), .PITCH_LO(3000), .PITCH_HI(5000)
    ) dut1 (
        .clk(clk), .reset(reset), .face_select(face1), .filter_mode(mode1),
        .mic_en(mic1), .pitch(pitch1), .data(data1), .startofpacket(sop1),
        .endofpacket(eop1), .valid(valid1), .ready(ready1), .frame_count(fc1)
    );

    frame_stream_filter #(
        .H_RES(4), .V_RES(2), .CH_BITS(2), .NUM_IMAGES(2), .PITCH_LO(3000), .PITCH_HI(5000)
    ) dut2 (
        .clk(clk), .reset(reset), .face_select(face2), .filter_mode(mode2),
        .mic_en(mic2), .pitch(pitch2), .data(data2), .startofpacket(sop2),
        .endofpacket(eop2), .valid(valid2), .ready(ready2), .frame_count(fc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] exp1(input logic [2:0] p);
        return {{8{p[2]}}, 2'b00, {8{p[1]}}, 2'b00, {8{p[0]}}, 2'b00};
    endfunction

    // Expected CH_BITS=1 pixel for beat i of a frame of the given kind.
    function automatic logic [2:0] exp_pix(input int kind, input int i);
        logic [2:0] p;
        logic       y;
        p = 3'(i);
        y = (p == 3'b111);
        case (kind)
            K_PASS:   return p;
            K_INV1:   return ~(p ^ 3'b010);
            K_ROTL:   return {p[1], p[0], p[2]};
            K_PK_LO:  return 3'b100;
            K_PK_HI:  return 3'b001;
            K_PK_MID: return {y, p[1], y};
            K_ROTR:   return {p[0], p[2], p[1]};
            default:  return {y, y, y};
        endcase
    endfunction

    task automatic next_beat(output logic [29:0] d, output logic s, output logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (!(valid1 && ready1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("handshake", 32'(valid1 && ready1), 32'd1);
        d = data1;
        s = sop1;
        e = eop1;
    endtask

    task automatic run_frame(input int kind, input int first, input int last,
                             input int exp_fc, input bit gap);
        logic [29:0] d;
        logic        s, e;
        for (int i = first; i <= last; i++) begin
            next_beat(d, s, e);
            if (gap) check_eq($sformatf("gap_k%0d_b%0d", kind, i), 32'(cyc - last_cyc), 32'd1);
            last_cyc = cyc;
            check_eq($sformatf("data_k%0d_b%0d", kind, i), 32'(d), 32'(exp1(exp_pix(kind, i))));
            check_eq($sformatf("sop_k%0d_b%0d", kind, i), 32'(s), 32'(i == 0));
            check_eq($sformatf("eop_k%0d_b%0d", kind, i), 32'(e), 32'(i == 7));
            if (i == 0) check_eq($sformatf("fcount_k%0d", kind), 32'(fc1), 32'(exp_fc));
        end
    endtask

    initial begin
        ready1 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                ready1 = bp_pat[bp_idx];
                bp_idx = (bp_idx + 1) % 4;
            end else begin
                ready1 = 1'b1;
            end
        end
    end

    // Outputs must not move while a beat is being held off.
    initial begin
        logic [29:0] pd;
        logic        ps, pe, stall;
        stall = 1'b0;
        pd = '0;
        ps = 1'b0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (stall && !reset) begin
                check_eq("hold_valid", 32'(valid1), 32'd1);
                check_eq("hold_data", 32'(data1), 32'(pd));
                check_eq("hold_sop", 32'(sop1), 32'(ps));
                check_eq("hold_eop", 32'(eop1), 32'(pe));
            end
            stall = valid1 && !ready1 && !reset;
            pd = data1;
            ps = sop1;
            pe = eop1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        face1  = 2'd0;  mode1 = 3'd0;  mic1 = 1'b0;  pitch1 = 16'd0;
        face2  = 1'b0;  mode2 = 3'd1;  mic2 = 1'b0;  pitch2 = 16'd0;
        ready2 = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            dut1.g_img[0].mem[i] = 3'(i);
            dut1.g_img[1].mem[i] = 3'(i) ^ 3'b010;
            dut1.g_img[2].mem[i] = 3'b101;
            dut2.g_img[0].mem[i] = 6'b11_10_00;
            dut2.g_img[1].mem[i] = 6'b00_00_00;
        end

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid1), 32'd0);
        check_eq("rst_data", 32'(data1), 32'd0);
        check_eq("rst_sop", 32'(sop1), 32'd0);
        check_eq("rst_eop", 32'(eop1), 32'd0);
        check_eq("rst_fcount", 32'(fc1), 32'd0);
        check_eq("rst_valid2", 32'(valid2), 32'd0);
        check_eq("rst_fcount2", 32'(fc2), 32'd0);
        reset = 1'b0;

        @(negedge clk);
        check_eq("lat_valid_edge1", 32'(valid1), 32'd0);
        last_cyc = cyc;

        run_frame(K_PASS, 0, 0, 0, 1'b1);
        check_eq("d2_valid", 32'(valid2), 32'd1);
        check_eq("d2_sop", 32'(sop2), 32'd1);
        check_eq("d2_eop", 32'(eop2), 32'd0);
        check_eq("d2_grey", 32'(data2), 32'({8'h55, 2'b00, 8'h55, 2'b00, 8'h55, 2'b00}));
        run_frame(K_PASS, 1, 7, 0, 1'b1);

        run_frame(K_PASS, 0, 3, 1, 1'b1);
        mode1 = 3'd4;  face1 = 2'd1;
        run_frame(K_PASS, 4, 7, 1, 1'b1);

        run_frame(K_INV1, 0, 0, 2, 1'b1);
        mode1 = 3'd2;  face1 = 2'd0;
        run_frame(K_INV1, 1, 7, 2, 1'b1);
        bp_on = 1'b1;

        run_frame(K_ROTL, 0, 0, 3, 1'b0);
        mode1 = 3'd5;  mic1 = 1'b1;  face1 = 2'd2;  pitch1 = 16'd3000;
        run_frame(K_ROTL, 1, 7, 3, 1'b0);
        bp_on = 1'b0;

        run_frame(K_PK_LO, 0, 0, 4, 1'b1);
        pitch1 = 16'd5001;
        run_frame(K_PK_LO, 1, 7, 4, 1'b1);

        run_frame(K_PK_HI, 0, 0, 5, 1'b1);
        face1 = 2'd0;  pitch1 = 16'd5000;
        run_frame(K_PK_HI, 1, 7, 5, 1'b1);

        run_frame(K_PK_MID, 0, 0, 6, 1'b1);
        face1 = 2'd3;  mode1 = 3'd3;
        run_frame(K_PK_MID, 1, 7, 6, 1'b1);

        run_frame(K_ROTR, 0, 0, 7, 1'b1);
        face1 = 2'd0;  mode1 = 3'd5;  mic1 = 1'b0;
        run_frame(K_ROTR, 1, 7, 7, 1'b1);

        run_frame(K_GREY, 0, 5, 8, 1'b1);
        mode1 = 3'd0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(valid1), 32'd0);
        check_eq("mid_rst_sop", 32'(sop1), 32'd0);
        check_eq("mid_rst_eop", 32'(eop1), 32'd0);
        check_eq("mid_rst_fcount", 32'(fc1), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("restart_valid_edge1", 32'(valid1), 32'd0);
        last_cyc = cyc;
        run_frame(K_PASS, 0, 7, 0, 1'b1);
        run_frame(K_PASS, 0, 0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
